// File: rtl/washer_ctrl_param.sv
// Washing-machine sequencer with internal wash/rinse/spin timers, rinse count, pause and sensor timeouts.
// Latency: state changes one clock after the qualifying input is sampled; outputs decode registered state only.
// Backpressure: none; pause freezes the timed phases, and sensor waits fault to ERROR after TIMEOUT_CYCLES.
module washer_ctrl_param #(
  parameter int WASH_CYCLES    = 8,
  parameter int RINSE_CYCLES   = 6,
  parameter int SPIN_CYCLES    = 4,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int MAX_RINSES     = 3,
  parameter int CW             = 8,
  parameter int RW             = 2
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          doorclose,
  input  logic          filled,
  input  logic          detergent,
  input  logic          drained,
  input  logic          pause,
  input  logic [RW-1:0] rinse_count,
  output logic          doorlock,
  output logic          fillvalve_on,
  output logic          drainvalve_on,
  output logic          soap_wash,
  output logic          water_wash,
  output logic          motor_on,
  output logic          done,
  output logic          error,
  output logic [3:0]    state
);

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0,
    S_FILL  = 4'd1,
    S_DET   = 4'd2,
    S_WASH  = 4'd3,
    S_RINSE = 4'd4,
    S_DRAIN = 4'd5,
    S_SPIN  = 4'd6,
    S_DONE  = 4'd7,
    S_ERROR = 4'd8
  } state_t;

  // Last timer value of each phase; the transition fires on the edge that sees it.
  localparam logic [CW-1:0] L_WASH_LAST  = CW'(WASH_CYCLES - 1);
  localparam logic [CW-1:0] L_RINSE_LAST = CW'(RINSE_CYCLES - 1);
  localparam logic [CW-1:0] L_SPIN_LAST  = CW'(SPIN_CYCLES - 1);
  localparam logic [CW-1:0] L_TO_LAST    = CW'(TIMEOUT_CYCLES - 1);

  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_timer;
  logic [RW-1:0]   r_rinses_left;
  logic            r_phase;        // 0: first fill feeds the wash, 1: fills feed a rinse
  logic            r_paused;       // pause was honoured on the last edge; masks the motor
  logic            w_door_fault;
  logic            w_active;       // states whose timer advances
  logic            w_hold;         // pause freezes the current timed phase
  logic            w_load;         // cycle start: capture rinse count
  logic            w_dec;          // a rinse pass begins
  logic [RW-1:0]   w_rinse_init;

  // Requested rinse count saturated at MAX_RINSES.
  always_comb begin
    w_rinse_init = rinse_count;
    if (int'(rinse_count) > MAX_RINSES) begin
      w_rinse_init = RW'(MAX_RINSES);
    end
  end

  // State register and per-state bookkeeping.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_timer       <= '0;
      r_rinses_left <= '0;
      r_phase       <= 1'b0;
      r_paused      <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_paused <= w_hold;
      if (w_next != r_state) begin
        r_timer <= '0;
      end else if (w_active && !w_hold) begin
        r_timer <= r_timer + 1'b1;
      end
      if (w_load) begin
        r_rinses_left <= w_rinse_init;
        r_phase       <= 1'b0;
      end else if (w_dec) begin
        r_rinses_left <= r_rinses_left - 1'b1;
        r_phase       <= 1'b1;
      end
    end
  end

  // Next-state logic and Moore output decode.
  always_comb begin
    w_next        = r_state;
    w_hold        = 1'b0;
    w_load        = 1'b0;
    w_dec         = 1'b0;
    w_active      = 1'b0;
    w_door_fault  = 1'b0;
    doorlock      = 1'b0;
    fillvalve_on  = 1'b0;
    drainvalve_on = 1'b0;
    soap_wash     = 1'b0;
    water_wash    = 1'b0;
    motor_on      = 1'b0;
    done          = 1'b0;
    error         = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (start && doorclose) begin
          w_next = S_FILL;
          w_load = 1'b1;
        end
      end
      S_FILL: begin
        w_active     = 1'b1;
        doorlock     = 1'b1;
        fillvalve_on = 1'b1;
        if (filled) begin
          w_next = r_phase ? S_RINSE : S_DET;
        end else if (r_timer == L_TO_LAST) begin
          w_next = S_ERROR;
        end
      end
      S_DET: begin
        w_active = 1'b1;
        doorlock = 1'b1;
        if (detergent) begin
          w_next = S_WASH;
        end else if (r_timer == L_TO_LAST) begin
          w_next = S_ERROR;
        end
      end
      S_WASH: begin
        w_active  = 1'b1;
        w_hold    = pause;
        doorlock  = 1'b1;
        soap_wash = 1'b1;
        motor_on  = !r_paused;
        if (!pause && r_timer == L_WASH_LAST) begin
          w_next = S_DRAIN;
        end
      end
      S_RINSE: begin
        w_active   = 1'b1;
        w_hold     = pause;
        doorlock   = 1'b1;
        water_wash = 1'b1;
        motor_on   = !r_paused;
        if (!pause && r_timer == L_RINSE_LAST) begin
          w_next = S_DRAIN;
        end
      end
      S_DRAIN: begin
        w_active      = 1'b1;
        doorlock      = 1'b1;
        drainvalve_on = 1'b1;
        if (drained) begin
          if (r_rinses_left != '0) begin
            w_next = S_FILL;
            w_dec  = 1'b1;
          end else begin
            w_next = S_SPIN;
          end
        end else if (r_timer == L_TO_LAST) begin
          w_next = S_ERROR;
        end
      end
      S_SPIN: begin
        w_active      = 1'b1;
        w_hold        = pause;
        doorlock      = 1'b1;
        drainvalve_on = 1'b1;
        motor_on      = !r_paused;
        if (!pause && r_timer == L_SPIN_LAST) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (!start) begin
          w_next = S_IDLE;
        end
      end
      S_ERROR: begin
        error = 1'b1;
      end
      default: begin
        w_next = S_ERROR;
      end
    endcase

    // An opened door while the drum is in use overrides everything else.
    w_door_fault = (r_state inside {S_FILL, S_DET, S_WASH, S_RINSE, S_DRAIN, S_SPIN}) && !doorclose;
    if (w_door_fault) begin
      w_next = S_ERROR;
      w_hold = 1'b0;
      w_dec  = 1'b0;
    end
  end

  assign state = r_state;

endmodule

// File: tb/tb_washer_ctrl_param.sv
// Directed bench for washer_ctrl_param: runs, rinses, pause, timeouts, door fault, reset, idle guard.
// A second instance with MAX_RINSES=2 checks rinse-count saturation.
// Outputs are sampled 1ns after the rising edge; inputs change right after sampling.
module tb_washer_ctrl_param;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0, doorclose = 1'b0, filled = 1'b0, detergent = 1'b0;
  logic       drained = 1'b0, pause = 1'b0;
  logic [1:0] rinse_count = 2'd0;

  logic       doorlock, fillvalve_on, drainvalve_on, soap_wash, water_wash, motor_on, done, error;
  logic [3:0] state;
  logic       doorlock2, fillvalve_on2, drainvalve_on2, soap_wash2, water_wash2, motor_on2, done2, error2;
  logic [3:0] state2;
  logic [7:0] outs;

  int n_chk  = 0;
  int n_fail = 0;
  int rins1  = 0;
  int rins2  = 0;
  logic prev1 = 1'b0, prev2 = 1'b0;

  assign outs = {doorlock, fillvalve_on, drainvalve_on, soap_wash, water_wash, motor_on, done, error};

  always #5 clk = ~clk;

  washer_ctrl_param dut (
    .clk(clk), .rst(rst), .start(start), .doorclose(doorclose), .filled(filled),
    .detergent(detergent), .drained(drained), .pause(pause), .rinse_count(rinse_count),
    .doorlock(doorlock), .fillvalve_on(fillvalve_on), .drainvalve_on(drainvalve_on),
    .soap_wash(soap_wash), .water_wash(water_wash), .motor_on(motor_on),
    .done(done), .error(error), .state(state)
  );

  washer_ctrl_param #(.MAX_RINSES(2)) dut2 (
    .clk(clk), .rst(rst), .start(start), .doorclose(doorclose), .filled(filled),
    .detergent(detergent), .drained(drained), .pause(pause), .rinse_count(rinse_count),
    .doorlock(doorlock2), .fillvalve_on(fillvalve_on2), .drainvalve_on(drainvalve_on2),
    .soap_wash(soap_wash2), .water_wash(water_wash2), .motor_on(motor_on2),
    .done(done2), .error(error2), .state(state2)
  );

  // Count rinse passes (rising edges of water_wash) on each instance.
  always @(negedge clk) begin
    if (rst) begin
      rins1 = 0; rins2 = 0; prev1 = 1'b0; prev2 = 1'b0;
    end else begin
      if (water_wash && !prev1) rins1++;
      if (water_wash2 && !prev2) rins2++;
      prev1 = water_wash;
      prev2 = water_wash2;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // 0: filled, 1: detergent, 2: drained -- high for one sampled edge.
  task automatic pulse(input int sel);
    case (sel)
      0: filled = 1'b1;
      1: detergent = 1'b1;
      default: drained = 1'b1;
    endcase
    tick();
    filled = 1'b0; detergent = 1'b0; drained = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return soap_wash;
      1: return water_wash;
      default: return motor_on && drainvalve_on;
    endcase
  endfunction

  // Number of sampled cycles (including the current one) the selected output stays high.
  task automatic wait_len(input int sel, output int n);
    n = 0;
    while (sig(sel) && n < 100) begin
      n++;
      tick();
    end
  endtask

  task automatic do_reset();
    start = 1'b0; doorclose = 1'b0; filled = 1'b0; detergent = 1'b0;
    drained = 1'b0; pause = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic begin_run(input logic [1:0] rc);
    do_reset();
    rinse_count = rc;
    start = 1'b1;
    doorclose = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #1;
    check("reset_state", state, 0);
    check("reset_outs", outs, 8'h00);
    tick();
    rst = 1'b0;
    check("post_reset_outs", outs, 8'h00);

    // Basic run, no rinses.
    begin_run(2'd0);
    check("fill_entry", state, 1);
    check("fill_outs", outs, 8'b1100_0000);
    tick();
    pulse(0);
    check("det_entry", state, 2);
    check("det_outs", outs, 8'b1000_0000);
    tick();
    pulse(1);
    check("wash_entry", state, 3);
    check("wash_outs", outs, 8'b1001_0100);
    wait_len(0, n);
    check("wash_len", n, 8);
    check("drain_entry", state, 5);
    check("drain_outs", outs, 8'b1010_0000);
    tick();
    pulse(2);
    check("spin_entry", state, 6);
    check("spin_outs", outs, 8'b1010_0100);
    wait_len(2, n);
    check("spin_len", n, 4);
    check("done_state", state, 7);
    check("done_outs", outs, 8'b0000_0010);
    tick(); tick();
    check("done_hold", state, 7);
    start = 1'b0;
    tick();
    check("idle_return", state, 0);
    check("idle_outs", outs, 8'h00);

    // Two rinse passes.
    begin_run(2'd2);
    pulse(0);
    pulse(1);
    wait_len(0, n);
    check("r2_wash_len", n, 8);
    pulse(2);
    check("r2_fill1", state, 1);
    pulse(0);
    check("r2_rinse1", state, 4);
    check("r2_rinse_outs", outs, 8'b1000_1100);
    wait_len(1, n);
    check("r2_rinse1_len", n, 6);
    pulse(2);
    check("r2_fill2", state, 1);
    pulse(0);
    check("r2_rinse2", state, 4);
    wait_len(1, n);
    check("r2_rinse2_len", n, 6);
    check("r2_drain2", state, 5);
    pulse(2);
    check("r2_spin", state, 6);

    // Saturation: rinse_count=3 on MAX_RINSES=3 and MAX_RINSES=2 instances.
    do_reset();
    rinse_count = 2'd3;
    filled = 1'b1; detergent = 1'b1; drained = 1'b1;
    start = 1'b1; doorclose = 1'b1;
    for (int i = 0; i < 400; i++) begin
      tick();
      if (done && done2) break;
    end
    filled = 1'b0; detergent = 1'b0; drained = 1'b0;
    check("sat_done1", done, 1);
    check("sat_done2", done2, 1);
    check("sat_rinses_max3", rins1, 3);
    check("sat_rinses_max2", rins2, 2);

    // Pause mid-wash at timer=3 for 5 clocks.
    begin_run(2'd0);
    pulse(0);
    pulse(1);
    tick(); tick(); tick();
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      check("pause_motor_off", motor_on, 0);
      check("pause_soap_on", soap_wash, 1);
    end
    pause = 1'b0;
    tick();
    check("pause_motor_back", motor_on, 1);
    wait_len(0, n);
    check("pause_wash_len", 9 + n, 13);

    // Fill timeout.
    begin_run(2'd0);
    repeat (15) tick();
    check("to_still_fill", state, 1);
    tick();
    check("to_error_state", state, 8);
    check("to_error_outs", outs, 8'b0000_0001);
    start = 1'b0;
    repeat (3) tick();
    check("to_error_held", state, 8);

    // filled on the last allowed clock wins over the timeout.
    begin_run(2'd0);
    repeat (15) tick();
    pulse(0);
    check("to_edge_det", state, 2);
    check("to_edge_noerr", error, 0);

    // Door opened during spin.
    begin_run(2'd0);
    pulse(0);
    pulse(1);
    wait_len(0, n);
    pulse(2);
    check("df_spin", state, 6);
    tick();
    doorclose = 1'b0;
    tick();
    check("df_error", state, 8);
    check("df_motor", motor_on, 0);

    // Asynchronous reset mid-rinse.
    begin_run(2'd1);
    pulse(0);
    pulse(1);
    wait_len(0, n);
    pulse(2);
    pulse(0);
    check("rr_rinse", state, 4);
    tick();
    #2;
    rst = 1'b1;
    #1;
    check("rr_async_state", state, 0);
    check("rr_async_outs", outs, 8'h00);
    @(posedge clk);
    #1;
    rst = 1'b0;
    tick();
    check("rr_restart", state, 1);

    // Start with door open stays in IDLE.
    do_reset();
    start = 1'b1;
    doorclose = 1'b0;
    repeat (3) tick();
    check("idle_guard_state", state, 0);
    check("idle_guard_outs", outs, 8'h00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/washer_ctrl_param.md
Name: washer_ctrl_param

Overview:
- Parametrised washing-machine sequencer, successor to the fixed single-cycle washer FSM.
- Adds internal wash, rinse and spin timers, a run-time programmable rinse count, pause support, and fill/drain/detergent timeout with an error state.
- Replaces the externally supplied cycletime_out/spintime_out handshakes.
- Sits between panel/sensor inputs and the actuator drivers.

Parameters:
- WASH_CYCLES, 8: clocks spent in WASH.
- RINSE_CYCLES, 6: clocks spent in each RINSE.
- SPIN_CYCLES, 4: clocks spent in SPIN.
- TIMEOUT_CYCLES, 16: maximum clocks allowed in FILL, DET or DRAIN before fault.
- MAX_RINSES, 3: saturation limit for requested rinse count.
- CW, 8: width of the shared timer; must hold max(all cycle parameters).
- RW, 2: width of rinse_count.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- start  in  1  run request, level.
- doorclose  in  1  door closed sensor.
- filled  in  1  water level reached.
- detergent  in  1  detergent added.
- drained  in  1  drum empty.
- pause  in  1  hold timed phases.
- rinse_count  in  RW  number of rinse passes, sampled at start.
- doorlock  out  1  door latch engaged.
- fillvalve_on  out  1  inlet valve open.
- drainvalve_on  out  1  drain valve open.
- soap_wash  out  1  soap wash phase active.
- water_wash  out  1  rinse phase active.
- motor_on  out  1  drum motor running.
- done  out  1  cycle complete.
- error  out  1  fault latched.
- state  out  4  current state encoding, for debug.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high.
  - On rst high, state=IDLE, timer=0, rinses_left=0, phase=WASH.
  - All outputs are 0 during reset and immediately after it.
- Outputs are Moore-decoded from registered state only. There is no combinational path from inputs to outputs.
- State encoding: IDLE=0, FILL=1, DET=2, WASH=3, RINSE=4, DRAIN=5, SPIN=6, DONE=7, ERROR=8.
- Timer: cleared on every state change; increments once per clock while in a timed or timeout-checked state.
- IDLE (all outputs 0):
  - start&&doorclose sampled high -> FILL on the same edge.
  - rinses_left <= min(rinse_count, MAX_RINSES); phase <= WASH.
  - start with door open: remain in IDLE.
- FILL (doorlock, fillvalve_on):
  - filled with phase=WASH -> DET; filled with phase=RINSE -> RINSE.
  - timer==TIMEOUT_CYCLES-1 without filled -> ERROR.
  - filled wins over timeout when both occur on the same cycle.
- DET (doorlock): detergent -> WASH; timeout -> ERROR, same rule as FILL.
- WASH (doorlock, motor_on, soap_wash): lasts exactly WASH_CYCLES unpaused clocks, then -> DRAIN.
- RINSE (doorlock, motor_on, water_wash): lasts exactly RINSE_CYCLES unpaused clocks, then -> DRAIN.
- DRAIN (doorlock, drainvalve_on):
  - drained with rinses_left>0 -> FILL; rinses_left decrements; phase <= RINSE.
  - drained with rinses_left==0 -> SPIN.
  - timeout -> ERROR; drained has priority over timeout.
- SPIN (doorlock, motor_on, drainvalve_on): lasts SPIN_CYCLES unpaused clocks, then -> DONE.
- Pause in WASH/RINSE/SPIN:
  - timer holds and motor_on drops to 0; soap_wash, water_wash and drainvalve_on keep their state values.
  - Pause has no effect in other states.
- Door fault: doorclose low in any state FILL..SPIN -> ERROR next edge. This has priority over every other transition.
- DONE (done=1, doorlock=0): held while start stays high; start low -> IDLE.
- ERROR (error=1, all other outputs 0): exits only via rst.
- Reset mid-cycle: all outputs drop asynchronously; the machine restarts from IDLE.

Test Plan:
- Basic run, defaults, rinse_count=0:
  - Stimulus: start=doorclose=1; filled 2 clocks after FILL entry; detergent 1 clock after DET entry; drained 1 clock after DRAIN entry.
  - Required: soap_wash high for exactly 8 clocks, motor_on with drainvalve_on for 4 clocks, then done=1 and doorlock=0.
  - Required: start low -> IDLE, all outputs 0.
- rinse_count=2:
  - Required: two FILL->RINSE->DRAIN passes follow the wash drain, each with water_wash high exactly 6 clocks and no DET visit, then SPIN.
  - rinse_count=3 with MAX_RINSES=2 -> exactly 2 rinses.
- Pause: assert pause for 5 clocks mid-WASH at timer=3 -> motor_on=0 for those 5 clocks; soap_wash total duration becomes 13 clocks.
- Timeouts:
  - filled never asserted -> ERROR after 16 clocks in FILL, error=1, all other outputs 0, ERROR held until rst.
  - filled asserted exactly on the 16th clock -> DET, no error.
- Door fault: doorclose=0 during SPIN -> state=ERROR next edge, motor_on=0.
- Reset: rst pulse mid-RINSE -> outputs 0 asynchronously, state=0.
- Idle guard: start=1 with doorclose=0 -> stays IDLE.
